// File: rtl/aha_tlx_rev_arbiter.sv
// Round-robin, credit-gated packet arbiter: NUM_REQ requesters onto the TLX REV payload link (stall counter under AHA_TLX_ARB_STATS_EN).
// Latency: a beat accepted in cycle N appears on REV_PAYLOAD in cycle N+1; 1 beat/cycle sustained.
// Backpressure: beats are accepted only when granted, credits > 0 and the output register is free or draining.
module aha_tlx_rev_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 80,
    parameter int MAX_CREDITS = 8
) (
    input  logic                      CLK,
    input  logic                      RESETn,
    input  logic [NUM_REQ-1:0]        REQ_TVALID,
    output logic [NUM_REQ-1:0]        REQ_TREADY,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_TDATA,
    input  logic [NUM_REQ-1:0]        REQ_TLAST,
    output logic                      REV_PAYLOAD_TVALID,
    input  logic                      REV_PAYLOAD_TREADY,
    output logic [DATA_W-1:0]         REV_PAYLOAD_TDATA,
    input  logic                      REV_FLOW_TVALID,
    output logic                      REV_FLOW_TREADY,
    input  logic [2:0]                REV_FLOW_TDATA,
    output logic [2:0]                GRANT_ID,
    output logic [3:0]                CREDITS,
    output logic [31:0]               STALL_CNT
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [2:0]          rr_ptr_q, rr_ptr_d;
    logic [2:0]          grant_id_q, grant_id_d;
    logic                out_vld_q, out_vld_d;
    logic [DATA_W-1:0]   out_dat_q, out_dat_d;
    logic [3:0]          credits_q, credits_d;
    logic                flow_rdy_q;

    logic                slot_free;
    logic                win_found;
    logic [2:0]          win_id;
    logic [3:0]          idx;
    logic [2:0]          grant_cur;
    logic                sel_vld;
    logic                sel_last;
    logic [DATA_W-1:0]   sel_dat;
    logic                acc;
    logic                flow_acc;
    logic [4:0]          credit_sum;
    logic [NUM_REQ-1:0]  req_rdy;

    always_comb begin
        slot_free = !out_vld_q || REV_PAYLOAD_TREADY;

        // Rotating search from rr_ptr; held off until the block is out of reset.
        win_found = 1'b0;
        win_id    = grant_id_q;
        idx       = '0;
        if (flow_rdy_q) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = {1'b0, rr_ptr_q} + 4'(k);
                if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!win_found && idx == 4'(i) && REQ_TVALID[i]) begin
                        win_found = 1'b1;
                        win_id    = 3'(i);
                    end
                end
            end
        end

        grant_cur = (state_q == LOCKED) ? grant_id_q : win_id;

        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_dat  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_cur == 3'(i)) begin
                sel_vld  = REQ_TVALID[i];
                sel_last = REQ_TLAST[i];
                sel_dat  = REQ_TDATA[i*DATA_W +: DATA_W];
            end
        end

        acc = flow_rdy_q && sel_vld && (credits_q != 4'd0) && slot_free &&
              ((state_q == LOCKED) || win_found);

        req_rdy = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_rdy[i] = acc && (grant_cur == 3'(i));
        end

        grant_id_d = grant_cur;
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        if (acc) begin
            if (sel_last) begin
                state_d  = IDLE;
                rr_ptr_d = (grant_cur == 3'(NUM_REQ - 1)) ? 3'd0 : grant_cur + 3'd1;
            end else begin
                state_d = LOCKED;
            end
        end

        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        if (acc) begin
            out_vld_d = 1'b1;
            out_dat_d = sel_dat;
        end else if (REV_PAYLOAD_TREADY) begin
            out_vld_d = 1'b0;
        end

        // Consume and return net in one 5-bit sum; acc implies credits_q >= 1, so no underflow.
        flow_acc   = REV_FLOW_TVALID && flow_rdy_q;
        credit_sum = {1'b0, credits_q} - {4'd0, acc} + (flow_acc ? {2'd0, REV_FLOW_TDATA} : 5'd0);
        credits_d  = (credit_sum > 5'(MAX_CREDITS)) ? 4'(MAX_CREDITS) : credit_sum[3:0];
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            credits_q  <= 4'(MAX_CREDITS);
            flow_rdy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            credits_q  <= credits_d;
            flow_rdy_q <= 1'b1;
        end
    end

    assign REQ_TREADY         = req_rdy;
    assign REV_PAYLOAD_TVALID = out_vld_q;
    assign REV_PAYLOAD_TDATA  = out_dat_q;
    assign REV_FLOW_TREADY    = flow_rdy_q;
    assign GRANT_ID           = grant_cur;
    assign CREDITS            = credits_q;

`ifdef AHA_TLX_ARB_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|REQ_TVALID) && (credits_q == 4'd0) && slot_free) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign STALL_CNT = stall_cnt_q;
`else
    assign STALL_CNT = 32'd0;
`endif

endmodule

// File: doc/aha_tlx_rev_arbiter.md
# aha_tlx_rev_arbiter

- Round-robin, credit-gated arbiter that merges up to NUM_REQ on-chip requesters onto the single TLX REV payload channel (80-bit AXI-Stream-style).
- Sits between the SoC-side TLX traffic sources and the TLX REV link.
- Grants whole packets, not single beats.
- Spends one link credit per beat; credits are replenished from the REV flow channel.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 80: payload width.
- MAX_CREDITS, 8: credit count after reset and saturation ceiling, 1..15.

Ports:
- CLK  in  1  single clock; all logic is on its rising edge.
- RESETn  in  1  reset, asynchronous and active-low.
- REQ_TVALID  in  NUM_REQ  per-requester valid.
- REQ_TREADY  out  NUM_REQ  per-requester ready.
- REQ_TDATA  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- REQ_TLAST  in  NUM_REQ  marks the last beat of a packet.
- REV_PAYLOAD_TVALID  out  1  link valid, registered.
- REV_PAYLOAD_TREADY  in  1  link ready.
- REV_PAYLOAD_TDATA  out  DATA_W  link data, registered.
- REV_FLOW_TVALID  in  1  credit-return valid.
- REV_FLOW_TREADY  out  1  credit-return ready.
- REV_FLOW_TDATA  in  3  credits returned, 0..7.
- GRANT_ID  out  3  current or last granted requester.
- CREDITS  out  4  current credit count.
- STALL_CNT  out  32  credit-stall cycle counter (see Configuration).

## Operation
- States: IDLE and LOCKED.
- Input accept condition. A beat from requester i is accepted when all of the following hold:
  - REQ_TVALID[i] is high;
  - i is granted;
  - CREDITS > 0;
  - the output slot is free, i.e. !REV_PAYLOAD_TVALID or REV_PAYLOAD_TREADY.
  - REQ_TREADY[i] equals this condition. It is never high for a non-granted requester.
- IDLE arbitration:
  - The grant is chosen combinationally.
  - Candidates are searched starting at rr_ptr and wrapping modulo NUM_REQ; the first requester with TVALID high wins.
  - The winner's first beat can be accepted in the same cycle.
  - If the accepted beat has TLAST=0, move to LOCKED on that requester.
  - If it has TLAST=1, stay in IDLE.
- LOCKED: only the locked requester is eligible. Accepting its TLAST beat returns the block to IDLE.
- Round-robin pointer:
  - On every accepted TLAST beat, rr_ptr becomes (winner+1) mod NUM_REQ.
  - rr_ptr does not move while a packet is incomplete.
- Output register:
  - An accepted beat loads REV_PAYLOAD_TDATA and sets REV_PAYLOAD_TVALID.
  - TVALID clears on REV_PAYLOAD_TREADY when no new beat is loaded in the same cycle.
  - Data is held stable while TVALID=1 and TREADY=0.
- Credits:
  - Each accepted beat costs 1 credit.
  - A REV_FLOW beat (TVALID and TREADY both high) adds REV_FLOW_TDATA credits.
  - The next value is CREDITS − consume + return, computed 5 bits wide and saturated to MAX_CREDITS.
  - Consume and return in the same cycle are netted.
  - With CREDITS=0 no beat is accepted, even one mid-packet; the lock is held.
- REV_FLOW_TREADY is a register: 0 in reset, 1 from the first clock after reset deasserts.
- GRANT_ID holds the last granted index while IDLE with no request.

## Timing
- Reset values:
  - REQ_TREADY = 0.
  - REV_PAYLOAD_TVALID = 0, REV_PAYLOAD_TDATA = 0.
  - REV_FLOW_TREADY = 0.
  - GRANT_ID = 0, rr_ptr = 0.
  - CREDITS = MAX_CREDITS.
  - STALL_CNT = 0.
  - State = IDLE.
- Latency: a beat accepted in cycle N is presented on REV_PAYLOAD in cycle N+1.
- Throughput: 1 beat/cycle with TREADY held high and credits available.
- Credits are usable in the cycle after the return beat; there is no same-cycle bypass.
- Reset asserted mid-packet:
  - all state returns to reset values immediately (asynchronously);
  - the partial packet is dropped;
  - requesters must restart the packet.

## Configuration
- AHA_TLX_ARB_STATS_EN defined:
  - STALL_CNT increments, wrapping at 2^32, on every cycle where any REQ_TVALID is high, CREDITS = 0, and the output slot is free.
  - Otherwise STALL_CNT holds its value.
- AHA_TLX_ARB_STATS_EN not defined: STALL_CNT is tied to 0 and no counter logic is built.

## Test plan
- Fairness: after reset, requesters 0..3 each send continuous single-beat packets (TLAST=1) with TREADY=1 and credits returned every cycle. Link order must be 0,1,2,3,0,1… with data matching each requester.
- Packet lock: req1 sends a 3-beat packet while req0 and req2 are valid. The link shows req1's 3 beats back-to-back, then req2, then req0.
- Credit exhaustion:
  - No flow returns, MAX_CREDITS=8, req0 streams 10 beats. Exactly 8 beats are accepted, then CREDITS=0 and REQ_TREADY=0.
  - A flow beat with TDATA=2 follows. The remaining 2 beats are accepted starting the next cycle.
- Backpressure: TREADY is held 0 for 5 cycles mid-stream. TDATA and TVALID stay stable, no beats are accepted, CREDITS is unchanged, and no data is lost or duplicated.
- Saturation and netting:
  - At CREDITS=7, one beat is consumed while TDATA=3 is returned in the same cycle. CREDITS becomes 8 (saturated).
  - At CREDITS=1, consume with return 1 leaves CREDITS=1.
- Stats/reset:
  - With AHA_TLX_ARB_STATS_EN: 20 cycles at CREDITS=0 with a request pending give STALL_CNT=20.
  - Asserting RESETn=0 mid-packet clears all outputs within the same cycle. Without the macro, STALL_CNT stays 0.
